// File: rtl/elevator_motor_controller.sv
// SCAN-order elevator motor and door sequencer driven by a divided tick.
// Define ELEVATOR_MOTOR_HOMING_EN to return the car to default_floor after an idle timeout.
module elevator_motor_controller #(
  parameter int FLOOR_COUNT  = 8,
  parameter int FLOOR_W      = $clog2(FLOOR_COUNT),
  parameter int TICK_DIV     = 1000000,
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3,
  parameter int IDLE_TICKS   = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FLOOR_W-1:0]     default_floor,
  input  logic [FLOOR_COUNT-1:0] queue_status,
  output logic                   up_ndown,
  output logic                   moving,
  output logic                   door_open,
  output logic [FLOOR_W-1:0]     current_floor,
  output logic [FLOOR_COUNT-1:0] service_ack
);

  localparam int TICK_W   = $clog2(TICK_DIV);
  localparam int TRAVEL_W = $clog2(TRAVEL_TICKS + 1);
  localparam int DOOR_W   = $clog2(DOOR_TICKS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_DOOR = 2'd2;
`ifdef ELEVATOR_MOTOR_HOMING_EN
  localparam logic [1:0] S_HOME = 2'd3;
  localparam int IDLE_W = $clog2(IDLE_TICKS + 1);
`endif

  logic [1:0]          state;
  logic [TICK_W-1:0]   tick_cnt;
  logic [TRAVEL_W-1:0] travel_cnt;
  logic [DOOR_W-1:0]   door_cnt;
  logic                tick;
  logic [FLOOR_W-1:0]  step_floor;
  logic                req_here, req_ahead, req_behind, req_at_step, req_past_step;
  logic                travel_done, door_done, keep_going;

  function automatic logic req_beyond(input logic [FLOOR_COUNT-1:0] q,
                                      input logic [FLOOR_W-1:0] f, input logic up);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOOR_COUNT; i++)
      if (up ? (i > int'(f)) : (i < int'(f))) r = r | q[i];
    return r;
  endfunction

  function automatic logic [FLOOR_COUNT-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    return FLOOR_COUNT'(1) << f;
  endfunction

  assign tick          = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign step_floor    = up_ndown ? current_floor + FLOOR_W'(1) : current_floor - FLOOR_W'(1);
  assign req_here      = queue_status[current_floor];
  assign req_ahead     = req_beyond(queue_status, current_floor, up_ndown);
  assign req_behind    = req_beyond(queue_status, current_floor, ~up_ndown);
  assign req_at_step   = queue_status[step_floor];
  assign req_past_step = req_beyond(queue_status, step_floor, up_ndown);
  assign travel_done   = tick && (travel_cnt == TRAVEL_W'(TRAVEL_TICKS - 1));
  assign door_done     = tick && (door_cnt == DOOR_W'(DOOR_TICKS - 1));

`ifdef ELEVATOR_MOTOR_HOMING_EN
  logic [FLOOR_W-1:0] home_target;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               idle_done;

  assign home_target = (int'(default_floor) > FLOOR_COUNT - 1) ? FLOOR_W'(FLOOR_COUNT - 1)
                                                                : default_floor;
  assign idle_done   = (idle_cnt == IDLE_W'(IDLE_TICKS)) ||
                       (tick && (idle_cnt == IDLE_W'(IDLE_TICKS - 1)));

  // Saturates so a car already at its home floor keeps re-checking if the target moves.
  always_ff @(posedge clk) begin
    if (reset || state != S_IDLE || queue_status != '0)
      idle_cnt <= '0;
    else if (tick && idle_cnt != IDLE_W'(IDLE_TICKS))
      idle_cnt <= idle_cnt + IDLE_W'(1);
  end
`else
  logic unused_default_floor;
  localparam int unused_idle_ticks = IDLE_TICKS;
  assign unused_default_floor = ^default_floor;
`endif

  always_comb begin
    keep_going = req_past_step;
`ifdef ELEVATOR_MOTOR_HOMING_EN
    if (state == S_HOME) keep_going = (step_floor != home_target);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + TICK_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      up_ndown      <= 1'b1;
      moving        <= 1'b0;
      door_open     <= 1'b0;
      current_floor <= '0;
      service_ack   <= '0;
      travel_cnt    <= '0;
      door_cnt      <= '0;
    end else begin
      service_ack <= '0;
      case (state)
        S_IDLE: begin
          if (req_here) begin
            state       <= S_DOOR;
            door_open   <= 1'b1;
            service_ack <= floor_bit(current_floor);
            door_cnt    <= '0;
          end else if (req_ahead || req_behind) begin
            if (!req_ahead) up_ndown <= ~up_ndown;
            state      <= S_MOVE;
            moving     <= 1'b1;
            travel_cnt <= '0;
          end
`ifdef ELEVATOR_MOTOR_HOMING_EN
          else if (idle_done && current_floor != home_target) begin
            up_ndown   <= (home_target > current_floor);
            state      <= S_HOME;
            moving     <= 1'b1;
            travel_cnt <= '0;
          end
`endif
        end
`ifdef ELEVATOR_MOTOR_HOMING_EN
        S_MOVE, S_HOME: begin
`else
        S_MOVE: begin
`endif
          if (travel_done) begin
            current_floor <= step_floor;
            travel_cnt    <= '0;
            if (req_at_step) begin
              state       <= S_DOOR;
              moving      <= 1'b0;
              door_open   <= 1'b1;
              service_ack <= floor_bit(step_floor);
              door_cnt    <= '0;
            end else if (!keep_going) begin
              state  <= S_IDLE;
              moving <= 1'b0;
            end
          end else if (tick) begin
            travel_cnt <= travel_cnt + TRAVEL_W'(1);
          end
        end
        S_DOOR: begin
          // The queue clears the bit the cycle after an ack, so a set bit outside the ack cycle is a new call.
          if (req_here && !service_ack[current_floor]) begin
            service_ack <= floor_bit(current_floor);
            door_cnt    <= '0;
          end else if (door_done) begin
            state     <= S_IDLE;
            door_open <= 1'b0;
            door_cnt  <= '0;
          end else if (tick) begin
            door_cnt <= door_cnt + DOOR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_motor_controller.sv
// Self-checking bench for elevator_motor_controller: directed scenarios followed by random
// requests, all outputs compared every cycle against a behavioural car model.
module tb_elevator_motor_controller;

  localparam int FC = 8;
  localparam int TD = 4;
  localparam int TT = 2;
  localparam int DT = 2;
  localparam int IT = 3;
`ifdef ELEVATOR_MOTOR_HOMING_EN
  localparam bit HOMING = 1'b1;
`else
  localparam bit HOMING = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [2:0]   default_floor;
  logic [FC-1:0] queue_status;
  logic         up_ndown, moving, door_open;
  logic [2:0]   current_floor;
  logic [FC-1:0] service_ack;

  int checks = 0;
  int failures = 0;

  elevator_motor_controller #(
    .FLOOR_COUNT(FC), .TICK_DIV(TD), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT), .IDLE_TICKS(IT)
  ) dut (
    .clk(clk), .reset(reset), .default_floor(default_floor), .queue_status(queue_status),
    .up_ndown(up_ndown), .moving(moving), .door_open(door_open),
    .current_floor(current_floor), .service_ack(service_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural car: countdowns of remaining ticks, tick derived from cycles since reset.
  typedef enum {M_IDLE, M_TRAVEL, M_DOOR, M_HOMING} mode_t;
  mode_t   m_mode;
  int      m_floor, m_legs, m_dwell, m_idle, m_since;
  bit      m_up;
  bit [FC-1:0] m_ack;

  function automatic bit anyBeyond(input bit [FC-1:0] q, input int f, input bit up);
    for (int i = 0; i < FC; i++)
      if (q[i] && (up ? i > f : i < f)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic openDoor();
    m_mode  = M_DOOR;
    m_ack   = '0;
    m_ack[m_floor] = 1'b1;
    m_dwell = DT;
  endtask

  task automatic modelStep(input bit [FC-1:0] q, input int dfl, input bit rst);
    bit tick;
    bit [FC-1:0] prev_ack;
    int target;
    tick     = (m_since % TD) == TD - 1;
    prev_ack = m_ack;
    m_ack    = '0;
    if (rst) begin
      m_mode = M_IDLE; m_floor = 0; m_up = 1'b1; m_legs = 0; m_dwell = 0;
      m_idle = 0; m_since = 0;
      return;
    end
    m_since++;
    target = (dfl > FC - 1) ? FC - 1 : dfl;
    case (m_mode)
      M_IDLE: begin
        if (q[m_floor]) openDoor();
        else if (anyBeyond(q, m_floor, m_up)) begin m_mode = M_TRAVEL; m_legs = TT; end
        else if (anyBeyond(q, m_floor, !m_up)) begin m_up = !m_up; m_mode = M_TRAVEL; m_legs = TT; end
        else if (HOMING) begin
          m_idle = m_idle + int'(tick);
          if (m_idle > IT) m_idle = IT;
          if (m_idle == IT && m_floor != target) begin
            m_up = target > m_floor; m_mode = M_HOMING; m_legs = TT;
          end
        end
        if (q != 0 || m_mode != M_IDLE) m_idle = 0;
      end
      M_TRAVEL, M_HOMING: begin
        m_idle = 0;
        if (tick) begin
          m_legs--;
          if (m_legs == 0) begin
            m_floor += m_up ? 1 : -1;
            if (q[m_floor]) openDoor();
            else if (m_mode == M_TRAVEL ? anyBeyond(q, m_floor, m_up) : m_floor != target) m_legs = TT;
            else m_mode = M_IDLE;
          end
        end
      end
      M_DOOR: begin
        m_idle = 0;
        if (q[m_floor] && !prev_ack[m_floor]) begin
          m_ack[m_floor] = 1'b1; m_dwell = DT;
        end else if (tick) begin
          m_dwell--;
          if (m_dwell == 0) m_mode = M_IDLE;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [FC-1:0] q, input logic [2:0] dfl, input logic rst);
    queue_status  = q;
    default_floor = dfl;
    reset         = rst;
  endtask

  // Predict the coming edge, let it happen, compare on the falling edge, then let the queue drop acked calls.
  task automatic stepCycle();
    modelStep(queue_status, int'(default_floor), reset);
    @(negedge clk);
    checkOutput("up_ndown", 32'(up_ndown), 32'(m_up));
    checkOutput("moving", 32'(moving), 32'(m_mode == M_TRAVEL || m_mode == M_HOMING));
    checkOutput("door_open", 32'(door_open), 32'(m_mode == M_DOOR));
    checkOutput("current_floor", 32'(current_floor), 32'(m_floor));
    checkOutput("service_ack", 32'(service_ack), 32'(m_ack));
    queue_status = queue_status & ~service_ack;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic waitForAck(input int bound, input string tag);
    int n;
    n = 0;
    do begin stepCycle(); n++; end while (service_ack == '0 && n < bound);
    checkOutput({tag, "_ack_seen"}, 32'(service_ack != '0), 32'd1);
  endtask

  task automatic waitForRest(input int floor, input int bound, input string tag);
    int n;
    n = 0;
    do begin stepCycle(); n++; end
    while (!(int'(current_floor) == floor && !moving) && n < bound);
    checkOutput({tag, "_reached"}, 32'(current_floor), 32'(floor));
  endtask

  task automatic waitForFloor(input int floor, input int bound, input string tag);
    int n;
    n = 0;
    do begin stepCycle(); n++; end while (int'(current_floor) != floor && n < bound);
    checkOutput({tag, "_floor"}, 32'(current_floor), 32'(floor));
  endtask

  initial begin
    // Reset values and a quiet car
    applyStimulus(8'h00, 3'd0, 1'b1);
    runCycles(2);
    checkOutput("rst_up_ndown", 32'(up_ndown), 32'd1);
    checkOutput("rst_moving", 32'(moving), 32'd0);
    checkOutput("rst_door_open", 32'(door_open), 32'd0);
    checkOutput("rst_floor", 32'(current_floor), 32'd0);
    checkOutput("rst_ack", 32'(service_ack), 32'd0);
    applyStimulus(8'h00, 3'd0, 1'b0);
    runCycles(100);
    checkOutput("quiet_moving", 32'(moving), 32'd0);
    checkOutput("quiet_floor", 32'(current_floor), 32'd0);

    // Single call to floor 3
    applyStimulus(8'h08, 3'd3, 1'b0);
    stepCycle();
    checkOutput("s2_moving_next", 32'(moving), 32'd1);
    waitForAck(60, "s2");
    checkOutput("s2_ack", 32'(service_ack), 32'h08);
    checkOutput("s2_floor", 32'(current_floor), 32'd3);
    runCycles(20);

    // SCAN: up to 5 first, then reverse to 1
    applyStimulus(8'h22, 3'd3, 1'b0);
    waitForAck(100, "s3a");
    checkOutput("s3_first_ack", 32'(service_ack), 32'h20);
    waitForAck(100, "s3b");
    checkOutput("s3_second_ack", 32'(service_ack), 32'h02);
    checkOutput("s3_dir_down", 32'(up_ndown), 32'd0);
    applyStimulus(queue_status, 3'd1, 1'b0);
    runCycles(12);

    // Call at the current floor opens the door at once; a repeat call restarts dwell
    applyStimulus(8'h10, 3'd4, 1'b0);
    waitForAck(60, "s4go");
    runCycles(12);
    applyStimulus(8'h10, 3'd4, 1'b0);
    stepCycle();
    checkOutput("s4_door_now", 32'(door_open), 32'd1);
    checkOutput("s4_ack_now", 32'(service_ack), 32'h10);
    runCycles(3);
    applyStimulus(queue_status | 8'h10, 3'd4, 1'b0);
    stepCycle();
    checkOutput("s4_reack", 32'(service_ack), 32'h10);
    runCycles(14);

    // Homing toward floor 6, interrupted by a call at 4
    applyStimulus(8'h04, 3'd2, 1'b0);
    waitForAck(60, "s5go");
    runCycles(12);
    applyStimulus(8'h00, 3'd6, 1'b0);
    if (HOMING) begin
      waitForFloor(3, 80, "s5home");
      applyStimulus(queue_status | 8'h10, 3'd6, 1'b0);
      waitForAck(40, "s5mid");
      checkOutput("s5_mid_ack", 32'(service_ack), 32'h10);
      waitForRest(6, 150, "s5rest");
      checkOutput("s5_no_door", 32'(door_open), 32'd0);
    end else begin
      runCycles(60);
      checkOutput("s5_stay_floor", 32'(current_floor), 32'd2);
      checkOutput("s5_stay_moving", 32'(moving), 32'd0);
    end

    // Reset while travelling between 2 and 3
    applyStimulus(8'h04, 3'd2, 1'b0);
    waitForAck(80, "s6go");
    runCycles(12);
    applyStimulus(8'h20, 3'd2, 1'b0);
    runCycles(4);
    checkOutput("s6_between_floor", 32'(current_floor), 32'd2);
    checkOutput("s6_between_moving", 32'(moving), 32'd1);
    applyStimulus(queue_status, 3'd2, 1'b1);
    stepCycle();
    checkOutput("s6_rst_floor", 32'(current_floor), 32'd0);
    checkOutput("s6_rst_moving", 32'(moving), 32'd0);
    checkOutput("s6_rst_ack", 32'(service_ack), 32'd0);
    applyStimulus(queue_status, 3'd2, 1'b0);

    // Random calls, home-floor changes and occasional resets
    for (int i = 0; i < 4000; i++) begin
      logic [FC-1:0] q;
      logic [2:0]    dfl;
      q   = queue_status;
      dfl = default_floor;
      if ($urandom_range(29) == 0) q[$urandom_range(FC - 1)] = 1'b1;
      if ($urandom_range(199) == 0) dfl = 3'($urandom_range(7));
      applyStimulus(q, dfl, $urandom_range(1499) == 0);
      stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
